// File: rtl/atmega_eep_sd_bridge.sv
// Bridges the MiSTer sd-block save image and the ATmega EEPROM ext_eep_* port (load on mount, save when dirty).
// Latency: EEPROM writes in the same clk as sd_buff_wr; save bytes follow ext_eep_addr by one clk (EEPROM read latency).
// Backpressure: none; HPS paces everything through sd_ack/sd_buff_wr, and save requests are held in a pending latch.
// Optional autosave after a quiet period is enabled by defining EEP_AUTOSAVE_EN.
module atmega_eep_sd_bridge #(
    parameter int EEP_SIZE = 1024
`ifdef EEP_AUTOSAVE_EN
    , parameter int AUTOSAVE_CYCLES = 24000000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic [63:0] img_size,
    input  logic        save_req,
    input  logic        eep_cpu_wr,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    output logic [16:0] ext_eep_addr,
    output logic [7:0]  ext_eep_data_in,
    output logic        ext_eep_data_wr,
    input  logic [7:0]  ext_eep_data_out,
    output logic        ext_eep_data_rd,
    output logic        ext_eep_data_en,
    output logic        busy,
    output logic        loaded,
    output logic        dirty
);

    localparam int NBLK = EEP_SIZE / 512;
    localparam int BW   = (NBLK > 1) ? $clog2(NBLK) : 1;

    typedef enum logic [2:0] {IDLE, LD_REQ, LD_XFER, SV_REQ, SV_XFER} state_t;

    state_t        state, state_nx;
    logic [BW-1:0] blk;
    logic          ro;
    logic          pending;
    logic          mount_ok;
    logic          last_blk;
    logic          xfer_end;
    logic          save_go;
    logic          ld_done;
    logic          auto_fire;

    // A mount only triggers a load when the image can hold the whole EEPROM.
    assign mount_ok = (img_size >= 64'(EEP_SIZE));
    assign last_blk = (blk == BW'(NBLK - 1));
    // sd_ack entered high in the XFER states, so a low sd_ack there is the falling edge.
    assign xfer_end = ((state == LD_XFER) || (state == SV_XFER)) && !sd_ack;
    // A mount in the same clk always wins over a save.
    assign save_go  = (state == IDLE) && !img_mounted && loaded && !ro && dirty && (pending || save_req);
    assign ld_done  = (state == LD_XFER) && !sd_ack && last_blk && !img_mounted;

`ifdef EEP_AUTOSAVE_EN
    logic [31:0] quiet_cnt;

    // Quiet-time counter: reload on every CPU write, count down while dirty and idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quiet_cnt <= 32'd0;
        end else if (eep_cpu_wr) begin
            quiet_cnt <= 32'(AUTOSAVE_CYCLES);
        end else if (dirty && (state == IDLE) && (quiet_cnt != 32'd0)) begin
            quiet_cnt <= quiet_cnt - 32'd1;
        end
    end

    assign auto_fire = !eep_cpu_wr && dirty && (state == IDLE) && (quiet_cnt == 32'd1);
`else
    assign auto_fire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a mount aborts any transfer and restarts from the idle rule.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (save_go) state_nx = SV_REQ;
            LD_REQ:  if (sd_ack) state_nx = LD_XFER;
            LD_XFER: if (!sd_ack) state_nx = last_blk ? IDLE : LD_REQ;
            SV_REQ:  if (sd_ack) state_nx = SV_XFER;
            SV_XFER: if (!sd_ack) state_nx = last_blk ? IDLE : SV_REQ;
            default: state_nx = IDLE;
        endcase
        if (img_mounted) begin
            state_nx = mount_ok ? LD_REQ : IDLE;
        end
    end

    // Block counter, image attributes and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk     <= '0;
            ro      <= 1'b0;
            loaded  <= 1'b0;
            dirty   <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (img_mounted || save_go) begin
                blk <= '0;
            end else if (xfer_end && !last_blk) begin
                blk <= blk + 1'b1;
            end

            if (img_mounted && mount_ok) begin
                ro <= img_readonly;
            end

            if (img_mounted) begin
                loaded <= 1'b0;
            end else if (ld_done) begin
                loaded <= 1'b1;
            end

            // CPU writes win over the snapshot clear so a write during save forces a re-save.
            if (eep_cpu_wr) begin
                dirty <= 1'b1;
            end else if (img_mounted || save_go || ld_done) begin
                dirty <= 1'b0;
            end

            if (img_mounted || save_go) begin
                pending <= 1'b0;
            end else if (save_req || auto_fire) begin
                pending <= 1'b1;
            end
        end
    end

    // Output decode: HPS requests in REQ states, EEPROM port ownership in XFER states.
    always_comb begin
        sd_lba          = 32'(blk);
        sd_rd           = 1'b0;
        sd_wr           = 1'b0;
        sd_buff_din     = 8'd0;
        ext_eep_addr    = 17'd0;
        ext_eep_data_in = 8'd0;
        ext_eep_data_wr = 1'b0;
        ext_eep_data_rd = 1'b0;
        ext_eep_data_en = 1'b0;
        busy            = (state != IDLE);
        case (state)
            LD_REQ:  sd_rd = !img_mounted;
            SV_REQ:  sd_wr = !img_mounted;
            LD_XFER: begin
                ext_eep_data_en = 1'b1;
                ext_eep_addr    = 17'({blk, sd_buff_addr});
                ext_eep_data_wr = sd_buff_wr;
                ext_eep_data_in = sd_buff_dout;
            end
            SV_XFER: begin
                ext_eep_data_en = 1'b1;
                ext_eep_data_rd = 1'b1;
                ext_eep_addr    = 17'({blk, sd_buff_addr});
                sd_buff_din     = ext_eep_data_out;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_atmega_eep_sd_bridge.sv
// Self-checking bench: random images served by an HPS model, EEPROM modelled as a byte array.
// Expected data comes from the bench's own image/EEPROM arrays and request counters.
// Autosave expectations follow whether EEP_AUTOSAVE_EN is defined.
module tb_atmega_eep_sd_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        img_mounted = 1'b0;
    logic        img_readonly = 1'b0;
    logic [63:0] img_size = 64'd0;
    logic        save_req = 1'b0;
    logic        eep_cpu_wr = 1'b0;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_ack = 1'b0;
    logic [8:0]  sd_buff_addr = 9'd0;
    logic [7:0]  sd_buff_dout = 8'd0;
    logic        sd_buff_wr = 1'b0;
    logic [7:0]  sd_buff_din;
    logic [16:0] ext_eep_addr;
    logic [7:0]  ext_eep_data_in;
    logic        ext_eep_data_wr;
    logic [7:0]  ext_eep_data_out = 8'd0;
    logic        ext_eep_data_rd;
    logic        ext_eep_data_en;
    logic        busy, loaded, dirty;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] img       [0:1023];
    logic [7:0] model_eep [0:1023];
    logic [7:0] eep_mem   [0:1023];
    int wr_cnt = 0;
    int rd_reqs = 0;
    int wr_reqs = 0;
    logic rd_q = 1'b0;
    logic wr_q = 1'b0;

    atmega_eep_sd_bridge #(
        .EEP_SIZE(1024)
`ifdef EEP_AUTOSAVE_EN
        , .AUTOSAVE_CYCLES(16)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
        .save_req(save_req), .eep_cpu_wr(eep_cpu_wr),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
        .sd_buff_din(sd_buff_din),
        .ext_eep_addr(ext_eep_addr), .ext_eep_data_in(ext_eep_data_in),
        .ext_eep_data_wr(ext_eep_data_wr), .ext_eep_data_out(ext_eep_data_out),
        .ext_eep_data_rd(ext_eep_data_rd), .ext_eep_data_en(ext_eep_data_en),
        .busy(busy), .loaded(loaded), .dirty(dirty)
    );

    always #5 clk = ~clk;

    // EEPROM model: synchronous write, one-clk registered read.
    always @(posedge clk) begin
        if (ext_eep_data_en && ext_eep_data_wr) begin
            eep_mem[ext_eep_addr[9:0]] <= ext_eep_data_in;
            wr_cnt <= wr_cnt + 1;
        end
        ext_eep_data_out <= eep_mem[ext_eep_addr[9:0]];
    end

    // Count distinct block requests issued to the HPS.
    always @(posedge clk) begin
        rd_q <= sd_rd;
        wr_q <= sd_wr;
        if (sd_rd && !rd_q) rd_reqs <= rd_reqs + 1;
        if (sd_wr && !wr_q) wr_reqs <= wr_reqs + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic new_image();
        for (int i = 0; i < 1024; i++) img[i] = 8'($urandom);
    endtask

    task automatic mount(input logic [63:0] sz, input logic r);
        img_size = sz;
        img_readonly = r;
        img_mounted = 1'b1;
        @(negedge clk);
        img_mounted = 1'b0;
    endtask

    task automatic pulse_save();
        save_req = 1'b1;
        @(negedge clk);
        save_req = 1'b0;
    endtask

    task automatic pulse_cpu();
        eep_cpu_wr = 1'b1;
        @(negedge clk);
        eep_cpu_wr = 1'b0;
    endtask

    task automatic chk_eep_content(input string tag);
        int errs = 0;
        for (int i = 0; i < 1024; i++) if (eep_mem[i] !== model_eep[i]) errs++;
        chk(tag, 64'(errs), 64'd0);
    endtask

    // HPS serving a block read; abort_at >= 0 pulls reset before that byte.
    task automatic serve_rd(input int lba, input int abort_at);
        int t = 0;
        int w0 = wr_cnt;
        while (!sd_rd && t < 200) begin @(negedge clk); t++; end
        if (!sd_rd) begin chk("rd_req_timeout", 64'd0, 64'd1); return; end
        chk("rd_lba", 64'(sd_lba), 64'(lba));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        sd_ack = 1'b1;
        @(negedge clk);
        chk("rd_drop", 64'(sd_rd), 64'd0);
        for (int k = 0; k < 512; k++) begin
            if (k == abort_at) begin
                rst = 1'b0;
                #1;
                chk("abort_ctl", 64'({sd_rd, sd_wr, busy, loaded, dirty, ext_eep_data_en,
                                      ext_eep_data_wr, ext_eep_data_rd}), 64'd0);
                chk("abort_bus", 64'({sd_lba, ext_eep_addr, ext_eep_data_in, sd_buff_din}), 64'd0);
                chk("abort_partial", 64'(wr_cnt - w0), 64'(abort_at));
                w0 = wr_cnt;
                for (int j = 0; j < 10; j++) begin
                    @(negedge clk);
                    sd_buff_addr = 9'(k + j);
                    sd_buff_wr = 1'b1;
                end
                @(negedge clk);
                sd_buff_wr = 1'b0;
                sd_ack = 1'b0;
                @(negedge clk);
                chk("abort_no_wr", 64'(wr_cnt - w0), 64'd0);
                rst = 1'b1;
                @(negedge clk);
                return;
            end
            sd_buff_addr = 9'(k);
            sd_buff_dout = img[lba * 512 + k];
            sd_buff_wr = 1'b1;
            @(negedge clk);
            sd_buff_wr = 1'b0;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        sd_ack = 1'b0;
        @(negedge clk);
    endtask

    // HPS serving a block write; cpu_at >= 0 pulses eep_cpu_wr at that byte.
    task automatic serve_wr(input int lba, input int cpu_at);
        int t = 0;
        int errs = 0;
        while (!sd_wr && t < 200) begin @(negedge clk); t++; end
        if (!sd_wr) begin chk("wr_req_timeout", 64'd0, 64'd1); return; end
        chk("wr_lba", 64'(sd_lba), 64'(lba));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        sd_ack = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 512; k++) begin
            sd_buff_addr = 9'(k);
            if (k == cpu_at) eep_cpu_wr = 1'b1;
            @(negedge clk);
            eep_cpu_wr = 1'b0;
            if (sd_buff_din !== model_eep[lba * 512 + k]) errs++;
        end
        chk("sv_data", 64'(errs), 64'd0);
        sd_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_full(input logic r);
        new_image();
        mount(64'd1024, r);
        serve_rd(0, -1);
        serve_rd(1, -1);
        for (int i = 0; i < 1024; i++) model_eep[i] = img[i];
    endtask

    initial begin
        int rd0, wr0, w0, t;
        repeat (3) @(negedge clk);
        chk("rst_ctl", 64'({sd_rd, sd_wr, busy, loaded, dirty, ext_eep_data_en,
                            ext_eep_data_wr, ext_eep_data_rd}), 64'd0);
        chk("rst_bus", 64'({sd_lba, ext_eep_addr, ext_eep_data_in, sd_buff_din}), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Full load of a read-write image.
        rd0 = rd_reqs; w0 = wr_cnt;
        load_full(1'b0);
        @(negedge clk);
        chk("ld_status", 64'({loaded, dirty, busy}), 64'b100);
        chk("ld_writes", 64'(wr_cnt - w0), 64'd1024);
        chk("ld_reqs", 64'(rd_reqs - rd0), 64'd2);
        chk_eep_content("ld_content");

        // CPU write then explicit save.
        pulse_cpu();
        chk("dirty_set", 64'(dirty), 64'd1);
        wr0 = wr_reqs;
        pulse_save();
        serve_wr(0, -1);
        serve_wr(1, -1);
        @(negedge clk);
        chk("sv_status", 64'({dirty, busy}), 64'b00);
        chk("sv_reqs", 64'(wr_reqs - wr0), 64'd2);

        // Undersized image: no load, no save.
        rd0 = rd_reqs; wr0 = wr_reqs;
        mount(64'd512, 1'b0);
        repeat (20) @(negedge clk);
        chk("small_no_rd", 64'(rd_reqs - rd0), 64'd0);
        chk("small_loaded", 64'(loaded), 64'd0);
        pulse_save();
        repeat (30) @(negedge clk);
        chk("small_no_wr", 64'(wr_reqs - wr0), 64'd0);

        // Read-only image loads but never saves.
        load_full(1'b1);
        @(negedge clk);
        chk("ro_loaded", 64'(loaded), 64'd1);
        chk_eep_content("ro_content");
        wr0 = wr_reqs;
        pulse_cpu();
        pulse_save();
        repeat (40) @(negedge clk);
        chk("ro_no_wr", 64'(wr_reqs - wr0), 64'd0);

        // Save request during load stays pending until the image becomes dirty.
        new_image();
        mount(64'd1024, 1'b0);
        serve_rd(0, -1);
        pulse_save();
        serve_rd(1, -1);
        for (int i = 0; i < 1024; i++) model_eep[i] = img[i];
        wr0 = wr_reqs;
        repeat (10) @(negedge clk);
        chk("pend_clean_no_wr", 64'(wr_reqs - wr0), 64'd0);
        pulse_cpu();
        serve_wr(0, 300);
        serve_wr(1, -1);
        @(negedge clk);
        chk("resave_dirty", 64'({dirty, busy}), 64'b10);

        // Mount and save in the same clk: mount wins, then reset mid-load.
        new_image();
        wr0 = wr_reqs;
        img_size = 64'd1024; img_readonly = 1'b0;
        img_mounted = 1'b1; save_req = 1'b1;
        @(negedge clk);
        img_mounted = 1'b0; save_req = 1'b0;
        serve_rd(0, 100);
        chk("mount_wins_no_wr", 64'(wr_reqs - wr0), 64'd0);
        chk("after_rst", 64'({loaded, busy, dirty}), 64'b000);

        // Quiet-time autosave.
        load_full(1'b0);
        @(negedge clk);
        pulse_cpu();
        t = 0;
        while (!sd_wr && t < 60) begin @(negedge clk); t++; end
`ifdef EEP_AUTOSAVE_EN
        chk("autosave_fire", 64'(sd_wr), 64'd1);
        chk("autosave_lat", 64'((t >= 14) && (t <= 22)), 64'd1);
        if (sd_wr) begin
            serve_wr(0, -1);
            serve_wr(1, -1);
            @(negedge clk);
            chk("autosave_clean", 64'(dirty), 64'd0);
        end
`else
        chk("no_autosave", 64'(sd_wr), 64'd0);
        chk("no_autosave_dirty", 64'(dirty), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
